// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue
// Command FIFO and sequencer in front of the gpu draw/clear engine. The bus
// bridge pushes draw/clear commands without polling busy. Each command is
// popped only while the gpu is idle. Its fields are held on ctrl_* for the
// whole command. After a one-cycle settle (LOAD), a single-cycle
// ctrl_draw/ctrl_clear strobe is issued (PULSE). The sequencer then waits for
// gpu_busy to drop (WAIT_DONE).
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   push handshake (cmd_ready = queue not full)
//   cmd_type              0 = draw, 1 = clear
//   cmd_*                 command fields captured on push
//   gpu_busy              gpu busy flag (high combinationally during the strobe)
//   ctrl_*                registered command fields to the gpu
//   ctrl_draw/ctrl_clear  one-cycle issue strobes
//   count                 queued entries, excluding the command in flight
//   cmd_done              one-cycle pulse as the in-flight command completes
//   idle                  nothing queued, nothing in flight, gpu not busy
module gpu_cmd_queue #(
    parameter int  DEPTH     = 8,
    parameter int  FB_WIDTH  = 400,
    parameter int  FB_HEIGHT = 240,
    localparam int WB        = $clog2(FB_WIDTH) + 2,
    localparam int HB        = $clog2(FB_HEIGHT) + 2,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_type,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [WB-1:0] cmd_width,
    input  logic [HB-1:0] cmd_height,
    input  logic [WB-1:0] cmd_x,
    input  logic [HB-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    input  logic          gpu_busy,
    output logic [31:0]   ctrl_address,
    output logic [15:0]   ctrl_address_x,
    output logic [15:0]   ctrl_address_y,
    output logic [15:0]   ctrl_image_width,
    output logic [WB-1:0] ctrl_width,
    output logic [HB-1:0] ctrl_height,
    output logic [WB-1:0] ctrl_x,
    output logic [HB-1:0] ctrl_y,
    output logic [15:0]   ctrl_clear_color,
    output logic          ctrl_draw,
    output logic          ctrl_clear,
    output logic [CW-1:0] count,
    output logic          cmd_done,
    output logic          idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + 32 + 16 + 16 + 16 + WB + HB + WB + HB + 16;

    typedef enum logic [1:0] {IDLE, LOAD, PULSE, WAIT_DONE} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] wr_entry;
    logic          push;
    logic          pop;
    logic          cur_type;

    logic          head_type;
    logic [31:0]   head_address;
    logic [15:0]   head_address_x;
    logic [15:0]   head_address_y;
    logic [15:0]   head_image_width;
    logic [WB-1:0] head_width;
    logic [HB-1:0] head_height;
    logic [WB-1:0] head_x;
    logic [HB-1:0] head_y;
    logic [15:0]   head_clear_color;

    // Full blocks pushes even when a pop happens on the same edge.
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0) && !gpu_busy;

    // Completion is flagged in the WAIT_DONE cycle where busy is seen low,
    // so a zero-duration gpu job reports done right after the strobe.
    assign cmd_done  = (state == WAIT_DONE) && !gpu_busy;
    assign idle      = (count == '0) && (state == IDLE) && !gpu_busy;

    assign wr_entry = {cmd_type, cmd_address, cmd_address_x, cmd_address_y,
                       cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y,
                       cmd_clear_color};

    assign {head_type, head_address, head_address_x, head_address_y,
            head_image_width, head_width, head_height, head_x, head_y,
            head_clear_color} = mem[rd_ptr];

    // Storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer: ctrl_* change only on a pop edge and are held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cur_type         <= 1'b0;
            ctrl_draw        <= 1'b0;
            ctrl_clear       <= 1'b0;
            ctrl_address     <= '0;
            ctrl_address_x   <= '0;
            ctrl_address_y   <= '0;
            ctrl_image_width <= '0;
            ctrl_width       <= '0;
            ctrl_height      <= '0;
            ctrl_x           <= '0;
            ctrl_y           <= '0;
            ctrl_clear_color <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_type         <= head_type;
                        ctrl_address     <= head_address;
                        ctrl_address_x   <= head_address_x;
                        ctrl_address_y   <= head_address_y;
                        ctrl_image_width <= head_image_width;
                        ctrl_width       <= head_width;
                        ctrl_height      <= head_height;
                        ctrl_x           <= head_x;
                        ctrl_y           <= head_y;
                        ctrl_clear_color <= head_clear_color;
                        state            <= LOAD;
                    end
                end
                // Fields settle one cycle before the strobe for the gpu's
                // registered base-address path.
                LOAD: begin
                    ctrl_draw  <= !cur_type;
                    ctrl_clear <= cur_type;
                    state      <= PULSE;
                end
                PULSE: begin
                    ctrl_draw  <= 1'b0;
                    ctrl_clear <= 1'b0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!gpu_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Testbench for gpu_cmd_queue: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model (a queue of pending
// commands and a "cycles since pop" counter for the command in flight).
module tb_gpu_cmd_queue;

    localparam int DEPTH     = 8;
    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int WB        = $clog2(FB_WIDTH) + 2;
    localparam int HB        = $clog2(FB_HEIGHT) + 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          typ;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [WB-1:0] width;
        logic [HB-1:0] height;
        logic [WB-1:0] x;
        logic [HB-1:0] y;
        logic [15:0]   clear_color;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    cmd_t          drv = '0;
    logic          cmd_ready;
    logic          gpu_busy;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x;
    logic [15:0]   ctrl_address_y;
    logic [15:0]   ctrl_image_width;
    logic [WB-1:0] ctrl_width;
    logic [HB-1:0] ctrl_height;
    logic [WB-1:0] ctrl_x;
    logic [HB-1:0] ctrl_y;
    logic [15:0]   ctrl_clear_color;
    logic          ctrl_draw;
    logic          ctrl_clear;
    logic [CW-1:0] count;
    logic          cmd_done;
    logic          idle;

    gpu_cmd_queue #(.DEPTH(DEPTH), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(drv.typ), .cmd_address(drv.address),
        .cmd_address_x(drv.address_x), .cmd_address_y(drv.address_y),
        .cmd_image_width(drv.image_width), .cmd_width(drv.width),
        .cmd_height(drv.height), .cmd_x(drv.x), .cmd_y(drv.y),
        .cmd_clear_color(drv.clear_color), .gpu_busy(gpu_busy),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
        .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color),
        .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear),
        .count(count), .cmd_done(cmd_done), .idle(idle)
    );

    always #5 clk = ~clk;

    // gpu model: busy combinationally with the strobe, then for dur cycles.
    int         dur = 8;
    logic       ext_busy = 1'b0;
    logic [7:0] busy_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset)                       busy_cnt <= '0;
        else if (ctrl_draw || ctrl_clear) busy_cnt <= 8'(dur);
        else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 8'd1;
    end

    assign gpu_busy = ext_busy || ctrl_draw || ctrl_clear || (busy_cnt != 0);

    // Reference model state.
    cmd_t q[$];
    cmd_t cur = '0;
    cmd_t last = '0;
    bit   inflight = 0;
    int   age = 0;
    bit   acc = 0;
    int   gap = 0;
    bit   have_prev = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.typ         = 1'($urandom_range(0, 1));
        c.address     = $urandom;
        c.address_x   = 16'($urandom);
        c.address_y   = 16'($urandom);
        c.image_width = 16'($urandom);
        c.width       = WB'($urandom);
        c.height      = HB'($urandom);
        c.x           = WB'($urandom);
        c.y           = HB'($urandom);
        c.clear_color = 16'($urandom);
        return c;
    endfunction

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic tick();
        cmd_t obs;
        cmd_t e;
        bit   exp_done;
        bit   do_pop;
        bit   do_push;
        #1;
        if (!reset) begin
            q.delete();
            inflight  = 0;
            cur       = '0;
            last      = '0;
            have_prev = 0;
        end
        obs = {1'b0, ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
               ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color};
        e = last;
        e.typ = 1'b0;
        exp_done = inflight && (age >= 3) && !gpu_busy;
        chk("count", count, q.size());
        chk("cmd_ready", cmd_ready, q.size() != DEPTH);
        chk("ctrl_draw", ctrl_draw, inflight && age == 2 && !cur.typ);
        chk("ctrl_clear", ctrl_clear, inflight && age == 2 && cur.typ);
        chk("strobes_both", ctrl_draw & ctrl_clear, 1'b0);
        chk("cmd_done", cmd_done, exp_done);
        chk("idle", idle, q.size() == 0 && !inflight && !gpu_busy);
        chk("ctrl_fields", obs, e);
        if (ctrl_draw || ctrl_clear) begin
            if (have_prev) chk("strobe_gap", gap >= 3, 1'b1);
            have_prev = 1;
            gap = 0;
        end else begin
            gap++;
        end
        acc = 0;
        if (reset) begin
            do_push = cmd_valid && (q.size() != DEPTH);
            do_pop  = !inflight && (q.size() != 0) && !gpu_busy;
            if (inflight) begin
                if (exp_done) inflight = 0;
                else          age++;
            end
            if (do_pop) begin
                cur = q.pop_front();
                last = cur;
                inflight = 1;
                age = 1;
            end
            if (do_push) begin
                q.push_back(drv);
                acc = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic push_cmd(input cmd_t c);
        int n;
        n = 0;
        drv = c;
        cmd_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        cmd_valid = 1'b0;
        chk("push_accept", acc, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("idle_reached", idle, 1'b1);
    endtask

    initial begin
        cmd_t c;
        int   n;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Single draw, gpu busy 8 cycles after the strobe.
        dur = 8;
        c = '0;
        c.address = 32'h1000; c.width = WB'(4); c.height = HB'(2);
        c.x = WB'(10); c.y = HB'(20);
        push_cmd(c);
        wait_idle();

        // Clear then draw back-to-back.
        dur = 5;
        c = rand_cmd(); c.typ = 1'b1; c.clear_color = 16'hF801;
        push_cmd(c);
        c = rand_cmd(); c.typ = 1'b0;
        push_cmd(c);
        wait_idle();

        // Fill past DEPTH while the gpu is held busy; order survives wrap.
        dur = 3;
        ext_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_cmd(rand_cmd());
        chk("full_ready", cmd_ready, 1'b0);
        drv = rand_cmd();
        cmd_valid = 1'b1;
        repeat (4) tick();
        ext_busy = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 100);
        cmd_valid = 1'b0;
        chk("ninth_accept", acc, 1'b1);
        wait_idle();

        // Push on the same edge as a pop with three queued.
        ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
        ext_busy = 1'b0;
        drv = rand_cmd();
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("pushpop_count", count, 3);
        wait_idle();

        // Reset in WAIT_DONE with four queued.
        dur = 20;
        for (int i = 0; i < 5; i++) push_cmd(rand_cmd());
        n = 0;
        while (!(inflight && age >= 4) && n < 50) begin
            tick();
            n++;
        end
        chk("reached_wait", count, 4);
        reset = 1'b0;
        tick();
        chk("rst_count", count, 0);
        tick();
        reset = 1'b1;
        repeat (10) tick();

        // Zero-duration gpu jobs.
        dur = 0;
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if (i % 97 == 0) dur = $urandom_range(0, 6);
            cmd_valid = ($urandom_range(0, 2) == 0);
            drv = rand_cmd();
            ext_busy = ($urandom_range(0, 15) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        ext_busy = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
